// File: rtl/booth_pkg.sv
// Shared types and Booth recoding helpers for the sequential radix-2 Booth multiplier.
// Imported by the iteration step and by the top-level controller.
package booth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // {Q[0],Q_1}: 01 adds M, 10 subtracts M, 00/11 leave the accumulator alone.
  function automatic logic [1:0] booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of M
// followed by an arithmetic right shift of {acc,Q,Q_1}.
module booth_r2_step
  import booth_pkg::*;
#(
  parameter int E = 9
) (
  input  logic [E:0]   acc,
  input  logic [E-1:0] q,
  input  logic         q_1,
  input  logic [E-1:0] m,
  output logic [E:0]   acc_next,
  output logic [E-1:0] q_next,
  output logic         q_1_next
);

  logic [E:0] m_ext;
  logic [E:0] sum;

  always_comb begin
    // One guard bit on the accumulator keeps acc +/- M from overflowing.
    m_ext = {m[E-1], m};
    case (booth_decode(q[0], q_1))
      BOOTH_ADD: sum = acc + m_ext;
      BOOTH_SUB: sum = acc - m_ext;
      default:   sum = acc;
    endcase
    acc_next = {sum[E], sum[E:1]};
    q_next   = {sum[0], q[E-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode, start/busy/done
// handshake, held product with valid flag, and synchronous abort.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic               product_valid
);

  localparam int E     = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_E   = CNT_W'(E);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [E:0]         acc_reg, acc_next;
  logic [E-1:0]       q_reg, q_next;
  logic               q_1_reg, q_1_next;
  logic [E-1:0]       m_reg, m_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [2*WIDTH-1:0] product_reg, product_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               valid_reg, valid_next;

  logic [E:0]         step_acc;
  logic [E-1:0]       step_q;
  logic               step_q_1;

  booth_r2_step #(.E(E)) u_step (
    .acc      (acc_reg),
    .q        (q_reg),
    .q_1      (q_1_reg),
    .m        (m_reg),
    .acc_next (step_acc),
    .q_next   (step_q),
    .q_1_next (step_q_1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      q_reg       <= '0;
      q_1_reg     <= 1'b0;
      m_reg       <= '0;
      count_reg   <= '0;
      product_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      q_reg       <= q_next;
      q_1_reg     <= q_1_next;
      m_reg       <= m_next;
      count_reg   <= count_next;
      product_reg <= product_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    q_next       = q_reg;
    q_1_next     = q_1_reg;
    m_next       = m_reg;
    count_next   = count_reg;
    product_next = product_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    valid_next   = valid_reg;
    case (state_reg)
      IDLE: begin
        // Extending by one bit lets the same signed Booth datapath handle unsigned operands.
        if (start && !abort) begin
          m_next     = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
          q_next     = is_signed ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
          acc_next   = '0;
          q_1_next   = 1'b0;
          count_next = CNT_E;
          state_next = CALC;
          busy_next  = 1'b1;
          valid_next = 1'b0;
        end
      end
      CALC: begin
        if (abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          acc_next   = step_acc;
          q_next     = step_q;
          q_1_next   = step_q_1;
          count_next = count_reg - CNT_ONE;
          if (count_reg == CNT_ONE) begin
            product_next = {step_acc[WIDTH-2:0], step_q};
            done_next    = 1'b1;
            valid_next   = 1'b1;
            busy_next    = 1'b0;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign product       = product_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign product_valid = valid_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench: directed handshake/abort/reset cases on an 8-bit instance,
// randomized signed/unsigned products on a 16-bit instance against plain arithmetic.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s8_start = 1'b0, s8_abort = 1'b0, s8_sgn = 1'b0;
  logic [7:0]  s8_a = '0, s8_b = '0;
  logic [15:0] p8;
  logic        busy8, done8, pv8;

  logic        s16_start = 1'b0, s16_abort = 1'b0, s16_sgn = 1'b0;
  logic [15:0] s16_a = '0, s16_b = '0;
  logic [31:0] p16;
  logic        busy16, done16, pv16;

  int          checks = 0;
  int          failures = 0;
  int          lat, bc;
  logic        seen;
  logic [15:0] ra, rb;
  logic        rs;
  longint      ea, eb;
  logic [31:0] expv;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .abort(s8_abort), .is_signed(s8_sgn),
    .multiplicand(s8_a), .multiplier(s8_b), .product(p8), .busy(busy8), .done(done8),
    .product_valid(pv8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16_start), .abort(s16_abort), .is_signed(s16_sgn),
    .multiplicand(s16_a), .multiplier(s16_b), .product(p16), .busy(busy16), .done(done16),
    .product_valid(pv16)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    s8_start = 1'b1; s8_a = a; s8_b = b; s8_sgn = sgn;
    @(negedge clk);
    s8_start = 1'b0;
  endtask

  // Called one negedge after the accepting edge; lat = edges from acceptance to done.
  task automatic wait8(output int lat_o, output int bc_o);
    int n;
    n = 1; bc_o = 0;
    while (!done8 && n <= 40) begin
      if (busy8) bc_o++;
      @(negedge clk);
      n++;
    end
    lat_o = done8 ? n - 1 : 0;
  endtask

  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    s16_start = 1'b1; s16_a = a; s16_b = b; s16_sgn = sgn;
    @(negedge clk);
    s16_start = 1'b0;
  endtask

  task automatic wait16(output int lat_o);
    int n;
    n = 1;
    while (!done16 && n <= 60) begin
      @(negedge clk);
      n++;
    end
    lat_o = done16 ? n - 1 : 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_valid", 32'(pv8), 32'd0);
    chk("reset_product", 32'(p8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start8(8'hFD, 8'h05, 1'b1);
    chk("t1_busy_after_start", 32'(busy8), 32'd1);
    wait8(lat, bc);
    $display("op s=1 A=0xfd B=0x05 product=0x%04h lat=%0d", p8, lat);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_busy_cycles", 32'(bc), 32'd9);
    chk("t1_product", 32'(p8), 32'hFFF1);
    chk("t1_valid", 32'(pv8), 32'd1);
    chk("t1_busy_at_done", 32'(busy8), 32'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done8), 32'd0);
    chk("t1_valid_held", 32'(pv8), 32'd1);

    start8(8'hFF, 8'hFF, 1'b0);
    wait8(lat, bc);
    $display("op s=0 A=0xff B=0xff product=0x%04h", p8);
    chk("t2_unsigned_ffxff", 32'(p8), 32'hFE01);
    @(negedge clk);
    start8(8'hFF, 8'hFF, 1'b1);
    wait8(lat, bc);
    $display("op s=1 A=0xff B=0xff product=0x%04h", p8);
    chk("t2_signed_ffxff", 32'(p8), 32'h0001);
    @(negedge clk);

    start8(8'h80, 8'h80, 1'b1);
    wait8(lat, bc);
    $display("op s=1 A=0x80 B=0x80 product=0x%04h", p8);
    chk("t3_min_x_min", 32'(p8), 32'h4000);
    chk("t3_latency", 32'(lat), 32'd9);
    start8(8'h7F, 8'h80, 1'b1);
    chk("t3_b2b_valid_cleared", 32'(pv8), 32'd0);
    chk("t3_b2b_busy", 32'(busy8), 32'd1);
    wait8(lat, bc);
    $display("op s=1 A=0x7f B=0x80 product=0x%04h lat=%0d", p8, lat);
    chk("t3_b2b_product", 32'(p8), 32'hC080);
    chk("t3_b2b_latency", 32'(lat), 32'd9);
    @(negedge clk);

    start8(8'h03, 8'h04, 1'b0);
    repeat (2) @(negedge clk);
    s8_start = 1'b1; s8_a = 8'h11; s8_b = 8'h11;
    @(negedge clk);
    s8_start = 1'b0;
    wait8(lat, bc);
    $display("op s=0 A=0x03 B=0x04 (start 0x11 ignored) product=0x%04h", p8);
    chk("t4_done_seen", 32'(done8), 32'd1);
    chk("t4_ignored_start", 32'(p8), 32'h000C);
    @(negedge clk);

    start8(8'h55, 8'h22, 1'b0);
    repeat (2) @(negedge clk);
    s8_abort = 1'b1;
    @(negedge clk);
    s8_abort = 1'b0;
    chk("t5_abort_busy", 32'(busy8), 32'd0);
    seen = 1'b0;
    repeat (15) begin
      if (done8) seen = 1'b1;
      @(negedge clk);
    end
    $display("op abort A=0x55 B=0x22 product=0x%04h valid=%0d", p8, pv8);
    chk("t5_abort_no_done", 32'(seen), 32'd0);
    chk("t5_abort_valid", 32'(pv8), 32'd0);
    chk("t5_abort_product_held", 32'(p8), 32'h000C);

    s8_abort = 1'b1; s8_start = 1'b1; s8_a = 8'h02; s8_b = 8'h02;
    @(negedge clk);
    s8_abort = 1'b0; s8_start = 1'b0;
    $display("op abort+start in idle busy=%0d", busy8);
    chk("t6_abort_wins_busy", 32'(busy8), 32'd0);
    repeat (12) @(negedge clk);
    chk("t6_abort_wins_product", 32'(p8), 32'h000C);

    start8(8'h07, 8'h09, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("op reset mid-calc busy=%0d product=0x%04h", busy8, p8);
    chk("t7_rst_busy", 32'(busy8), 32'd0);
    chk("t7_rst_done", 32'(done8), 32'd0);
    chk("t7_rst_valid", 32'(pv8), 32'd0);
    chk("t7_rst_product", 32'(p8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start8(8'h07, 8'h09, 1'b0);
    wait8(lat, bc);
    $display("op s=0 A=0x07 B=0x09 after reset product=0x%04h", p8);
    chk("t7_after_reset_product", 32'(p8), 32'h003F);
    chk("t7_after_reset_latency", 32'(lat), 32'd9);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        ra = 16'h8000; rb = 16'h8000; rs = 1'b1;
      end else if (i == 1) begin
        ra = 16'hFFFF; rb = 16'hFFFF; rs = 1'b0;
      end else begin
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      end
      ea   = rs ? longint'($signed(ra)) : longint'(ra);
      eb   = rs ? longint'($signed(rb)) : longint'(rb);
      expv = 32'(ea * eb);
      start16(ra, rb, rs);
      wait16(lat);
      $display("op16 s=%0d A=0x%04h B=0x%04h product=0x%08h expected=0x%08h lat=%0d",
               rs, ra, rb, p16, expv, lat);
      chk("r16_product", p16, expv);
      chk("r16_latency", 32'(lat), 32'd17);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier. Successor to the fixed 8-bit signed multiplier in the arithmetic unit. Adds:
- a WIDTH parameter;
- per-operation signed/unsigned mode;
- a start/busy/done handshake with a held product and product-valid flag;
- a synchronous abort.

It sits in the arithmetic unit beside the adder/subtractor, driven by the ALU controller.

Parameters:
WIDTH, 8, operand width in bits (>= 2).
CNT_W, $clog2(WIDTH+2), iteration counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
abort  input  1  synchronous cancel of a running operation
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
multiplicand  input  WIDTH  operand A; sampled with start
multiplier  input  WIDTH  operand B; sampled with start
product  output  2*WIDTH  result; held until next accepted start
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
product_valid  output  1  product holds a completed result

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; product=0; busy=0; done=0; product_valid=0; accumulator, Q, Q_1 and counter all 0.
- Internal width E=WIDTH+1. Operands are extended to E bits at capture:
  - sign-extended if is_signed=1;
  - zero-extended if is_signed=0.
  - This makes one Booth datapath serve both modes.
- State machine: IDLE -> CALC -> IDLE.
- IDLE, start=1, abort=0 (edge k):
  - capture the extended multiplicand M;
  - acc <= 0, Q <= extended multiplier, Q_1 <= 0, count <= E;
  - state <= CALC; busy <= 1; product_valid <= 0.
- CALC, each edge:
  - {Q[0],Q_1} = 01: acc+M; 10: acc-M; 00/11: acc unchanged;
  - arithmetic right shift of {acc,Q,Q_1} by one (acc MSB replicated);
  - count decrements.
- Accumulator is E+1 bits, so acc±M cannot overflow.
- On the edge that performs the iteration with count==1:
  - product <= low 2*WIDTH bits of the final {acc,Q};
  - done <= 1 for exactly one cycle; product_valid <= 1;
  - busy <= 0; state <= IDLE.
- Latency: start sampled at edge k gives done=1 and a valid product in the cycle after edge k+E. busy is high for exactly E cycles.
- A start sampled while done=1 is accepted (back-to-back operation). That start clears product_valid at the next edge.
- start while busy=1 is ignored: operands are not resampled and no error is flagged.
- abort=1 in CALC:
  - state <= IDLE, busy <= 0, no done pulse, product_valid stays 0;
  - product is not updated and retains its prior value.
- abort=1 in IDLE: no effect.
- Simultaneous abort and start in IDLE: abort wins; start is dropped.
- Reset mid-operation: all outputs return to reset values immediately. No result is produced.
- Results for the extremes: signed -2^(W-1) × -2^(W-1) = 2^(2W-2), unsigned (2^W-1)^2; both are exact in 2*WIDTH bits. No overflow output exists.

Decomposition:
- Shared package booth_pkg:
  - state enum type (IDLE, CALC);
  - Booth op encoding constants (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB), derived from {Q[0],Q_1}.
- One natural sub-module, booth_r2_step: combinational single iteration.
  - Inputs: acc, Q, Q_1, M.
  - Outputs: next acc, next Q, next Q_1.
  - Parametrised by E.
- The top level holds registers, the counter, the FSM and the handshake.

Test Plan:
- WIDTH=8, is_signed=1, A=0xFD (-3), B=0x05 -> done exactly 9 cycles after start edge; product=0xFFF1; product_valid=1; busy high for 9 cycles.
- WIDTH=8, is_signed=0, A=0xFF, B=0xFF -> product=0xFE01. The same operands with is_signed=1 -> product=0x0001.
- WIDTH=8, signed, A=0x80, B=0x80 -> product=0x4000. Then, with start held in the done cycle, A=0x7F, B=0x80 -> product=0xC080, with no idle gap.
- Start A=0x03, B=0x04; pulse start with A=0x11, B=0x11 at cycle 3 of CALC -> product=0x000C. Abort during a later operation -> no done, product_valid=0, product stays 0x000C.
- rst_n low mid-CALC (cycle 4) -> busy, done, product_valid and product all 0 immediately. A new start after release works normally.
- WIDTH=16, random signed and unsigned pairs (≥1000) vs a reference model. Latency is 17 cycles each; product matches A*B exactly in 32 bits.
